// File: rtl/blake_core_scheduler.sv
// Round-robin nonce dispatcher for NCORES Blake cores plus golden-nonce hold/arbiter/FIFO.
// Optional feature: define SCHED_HIT_COUNT_EN to enable the saturating hit_count counter.
module blake_core_scheduler #(
    parameter int NCORES     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   work_load,
    input  logic [31:0]            nonce_start,
    output logic [NCORES-1:0]      core_start,
    output logic [31:0]            core_nonce,
    input  logic [NCORES-1:0]      core_busy,
    input  logic [NCORES-1:0]      core_hit,
    input  logic [32*NCORES-1:0]   core_hit_nonce,
    output logic                   gn_valid,
    output logic [31:0]            gn_nonce,
    input  logic                   gn_ack,
    output logic                   gn_overflow,
    output logic                   running,
    output logic                   exhausted,
    output logic [15:0]            hit_count
);
    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t              state_q;
    logic [31:0]         next_nonce_q;
    logic [PW-1:0]       rr_q;
    logic [NCORES-1:0]   core_start_q;
    logic [31:0]         core_nonce_q;
    logic                running_q;
    logic                exhausted_q;
    logic                gn_overflow_q;

    logic                dispatch_en;
    logic [31:0]         issue_nonce;
    logic [NCORES-1:0]   avail;
    logic                found;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       rr_next;
    logic [PW:0]         cand;

    assign dispatch_en = work_load || (state_q == DISPATCH);
    assign issue_nonce = work_load ? nonce_start : next_nonce_q;
    // Cores pulsed this cycle do not show busy yet, so mask them for one cycle.
    assign avail       = ~core_busy & ~core_start_q;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand = {1'b0, rr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NCORES))
                cand = cand - (PW+1)'(NCORES);
            if (!found && avail[cand[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign rr_next = (win_idx == PW'(NCORES - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            next_nonce_q <= '0;
            rr_q         <= '0;
            core_start_q <= '0;
            core_nonce_q <= '0;
            running_q    <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            core_start_q <= '0;
            if (work_load) begin
                next_nonce_q <= nonce_start;
                exhausted_q  <= 1'b0;
                state_q      <= DISPATCH;
                running_q    <= 1'b1;
            end else if (state_q == DRAIN && core_busy == '0 && core_start_q == '0) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
            end
            if (dispatch_en && found) begin
                core_start_q[win_idx] <= 1'b1;
                core_nonce_q          <= issue_nonce;
                next_nonce_q          <= issue_nonce + 32'd1;
                rr_q                  <= rr_next;
                if (issue_nonce == 32'hFFFF_FFFF) begin
                    exhausted_q <= 1'b1;
                    state_q     <= DRAIN;
                    running_q   <= 1'b1;
                end
            end
        end
    end

    // Golden-nonce capture: one hold register per core.
    logic [NCORES-1:0]   hold_valid;
    logic [31:0]         hold_nonce [NCORES];
    logic [NCORES-1:0]   hold_pop;
    logic [NCORES-1:0]   hit_accept;
    logic [NCORES-1:0]   hit_drop;

    for (genvar gi = 0; gi < NCORES; gi++) begin : g_hold
        logic        valid_q;
        logic [31:0] nonce_q;

        assign hit_accept[gi] = core_hit[gi] && (!valid_q || hold_pop[gi]);
        assign hit_drop[gi]   = core_hit[gi] && valid_q && !hold_pop[gi];
        assign hold_valid[gi] = valid_q;
        assign hold_nonce[gi] = nonce_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                nonce_q <= '0;
            end else if (hit_accept[gi]) begin
                valid_q <= 1'b1;
                nonce_q <= core_hit_nonce[32*gi +: 32];
            end else if (hold_pop[gi]) begin
                valid_q <= 1'b0;
            end
        end
    end

    logic [PW-1:0]       hit_rr_q;
    logic                hfound;
    logic [PW-1:0]       hsel;
    logic [PW:0]         hcand;
    logic [31:0]         fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW-1:0]       rd_ptr_d;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [31:0]         push_data;
    logic [31:0]         head_d;
    logic                gn_valid_q;
    logic [31:0]         gn_nonce_q;

    always_comb begin
        hfound = 1'b0;
        hsel   = '0;
        hcand  = '0;
        for (int k = 0; k < NCORES; k++) begin
            hcand = {1'b0, hit_rr_q} + (PW+1)'(k);
            if (hcand >= (PW+1)'(NCORES))
                hcand = hcand - (PW+1)'(NCORES);
            if (!hfound && hold_valid[hcand[PW-1:0]]) begin
                hfound = 1'b1;
                hsel   = hcand[PW-1:0];
            end
        end
    end

    assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop       = gn_ack && gn_valid_q;
    assign push      = hfound && (!fifo_full || pop);
    assign push_data = hold_nonce[hsel];
    assign rd_ptr_d  = rd_ptr_q + AW'(pop);
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // The slot being written becomes the head only when the FIFO is otherwise empty.
    assign head_d    = (push && wr_ptr_q == rd_ptr_d) ? push_data : fifo_mem_q[rd_ptr_d];

    always_comb begin
        hold_pop = '0;
        if (push)
            hold_pop[hsel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_rr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            gn_valid_q    <= 1'b0;
            gn_nonce_q    <= '0;
            gn_overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                hit_rr_q <= (hsel == PW'(NCORES - 1)) ? '0 : hsel + 1'b1;
            end
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gn_valid_q <= (count_d != '0);
            if (count_d != '0)
                gn_nonce_q <= head_d;
            if (|hit_drop)
                gn_overflow_q <= 1'b1;
            else if (work_load)
                gn_overflow_q <= 1'b0;
        end
    end

`ifdef SCHED_HIT_COUNT_EN
    logic [15:0] hit_count_q;
    logic [4:0]  accept_cnt;
    logic [16:0] hit_sum;

    always_comb begin
        accept_cnt = '0;
        for (int k = 0; k < NCORES; k++)
            accept_cnt = accept_cnt + 5'(hit_accept[k]);
    end

    assign hit_sum = {1'b0, (work_load ? 16'd0 : hit_count_q)} + {12'd0, accept_cnt};

    always_ff @(posedge clk) begin
        if (reset)
            hit_count_q <= '0;
        else
            hit_count_q <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    end

    assign hit_count = hit_count_q;
`else
    assign hit_count = 16'd0;
`endif

    assign core_start  = core_start_q;
    assign core_nonce  = core_nonce_q;
    assign gn_valid    = gn_valid_q;
    assign gn_nonce    = gn_nonce_q;
    assign gn_overflow = gn_overflow_q;
    assign running     = running_q;
    assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_blake_core_scheduler.sv
// Scoreboard bench for blake_core_scheduler: models cores busy for 10 cycles after each start,
// queues expected starts and golden nonces, compares as the DUT produces them.
`timescale 1ns/1ps
module tb_blake_core_scheduler;
    localparam int NC       = 4;
    localparam int BUSY_LEN = 10;
`ifdef SCHED_HIT_COUNT_EN
    localparam bit HC_EN = 1'b1;
`else
    localparam bit HC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              work_load;
    logic [31:0]       nonce_start;
    logic [NC-1:0]     core_start;
    logic [31:0]       core_nonce;
    logic [NC-1:0]     core_busy;
    logic [NC-1:0]     core_hit;
    logic [32*NC-1:0]  core_hit_nonce;
    logic              gn_valid;
    logic [31:0]       gn_nonce;
    logic              gn_ack;
    logic              gn_overflow;
    logic              running;
    logic              exhausted;
    logic [15:0]       hit_count;

    always #5 clk = ~clk;

    blake_core_scheduler #(.NCORES(NC), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .work_load      (work_load),
        .nonce_start    (nonce_start),
        .core_start     (core_start),
        .core_nonce     (core_nonce),
        .core_busy      (core_busy),
        .core_hit       (core_hit),
        .core_hit_nonce (core_hit_nonce),
        .gn_valid       (gn_valid),
        .gn_nonce       (gn_nonce),
        .gn_ack         (gn_ack),
        .gn_overflow    (gn_overflow),
        .running        (running),
        .exhausted      (exhausted),
        .hit_count      (hit_count)
    );

    int            checks_cnt = 0;
    int            errors_cnt = 0;
    int            cycle      = 0;
    int            busy_cnt [NC];
    logic [NC-1:0] prev_start;
    logic [35:0]   start_q [$];
    logic [31:0]   gn_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One clock: advance core busy model, then score any start pulse.
    task automatic tick();
        logic [35:0] e;
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NC; i++) begin
            if (busy_cnt[i] > 0)
                busy_cnt[i]--;
            if (prev_start[i])
                busy_cnt[i] = BUSY_LEN;
            core_busy[i] = (busy_cnt[i] > 0);
        end
        if (core_start != '0) begin
            if (start_q.size() == 0) begin
                check_val("start_unexp", {28'd0, core_start}, 32'd0);
            end else begin
                e = start_q.pop_front();
                check_val("start_vec", {28'd0, core_start}, {28'd0, e[35:32]});
                check_val("start_nonce", core_nonce, e[31:0]);
                $display("cycle %0d start core=%b nonce=%08h", cycle, core_start, core_nonce);
            end
        end
        prev_start = core_start;
    endtask

    task automatic drive_hit(input logic [NC-1:0] mask, input logic [31:0] base);
        for (int i = 0; i < NC; i++)
            core_hit_nonce[32*i +: 32] = base + i;
        core_hit = mask;
        $display("cycle %0d hit mask=%b base=%08h", cycle, mask, base);
        tick();
        core_hit = '0;
    endtask

    task automatic pop_one();
        logic [31:0] e;
        int n;
        n = 0;
        while (!gn_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("gn_valid_wait", {31'd0, gn_valid}, 32'd1);
        e = (gn_q.size() > 0) ? gn_q.pop_front() : 32'hDEAD_BEEF;
        check_val("gn_nonce", gn_nonce, e);
        $display("cycle %0d pop nonce=%08h", cycle, gn_nonce);
        gn_ack = 1'b1;
        tick();
        gn_ack = 1'b0;
    endtask

    task automatic load(input logic [31:0] ns);
        nonce_start = ns;
        work_load   = 1'b1;
        tick();
        work_load   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (core_busy != '0 && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_busy_low"}, {28'd0, core_busy}, 32'd0);
        check_val({tag, "_run_hold"}, {31'd0, running}, 32'd1);
        tick();
        check_val({tag, "_run_fall"}, {31'd0, running}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_start"}, {28'd0, core_start}, 32'd0);
        check_val({tag, "_cnonce"}, core_nonce, 32'd0);
        check_val({tag, "_gvalid"}, {31'd0, gn_valid}, 32'd0);
        check_val({tag, "_gnonce"}, gn_nonce, 32'd0);
        check_val({tag, "_ovf"}, {31'd0, gn_overflow}, 32'd0);
        check_val({tag, "_run"}, {31'd0, running}, 32'd0);
        check_val({tag, "_exh"}, {31'd0, exhausted}, 32'd0);
        check_val({tag, "_hcnt"}, {16'd0, hit_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        reset = 1'b1; work_load = 1'b0; nonce_start = '0; gn_ack = 1'b0;
        core_hit = '0; core_hit_nonce = '0; core_busy = '0; prev_start = '0;
        for (int i = 0; i < NC; i++)
            busy_cnt[i] = 0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Round-robin fill of four idle cores, then restart after first core frees.
        for (int i = 0; i < NC; i++)
            start_q.push_back({4'(1 << i), 32'h100 + 32'(i)});
        t0 = cycle;
        load(32'h100);
        check_val("t1_running", {31'd0, running}, 32'd1);
        tick(); tick(); tick();
        check_val("t1_q_empty", start_q.size(), 32'd0);
        start_q.push_back({4'b0001, 32'h104});
        n = 0;
        do begin
            tick();
            n++;
        end while (core_start == '0 && n < 30);
        check_val("t1_restart_cyc", cycle - t0, 32'd13);

        // Reload near the top of nonce space: two starts then drain.
        start_q.push_back({4'b0010, 32'hFFFF_FFFE});
        start_q.push_back({4'b0100, 32'hFFFF_FFFF});
        load(32'hFFFF_FFFE);
        check_val("t2_exh_lo", {31'd0, exhausted}, 32'd0);
        tick();
        check_val("t2_exh_hi", {31'd0, exhausted}, 32'd1);
        check_val("t2_q_empty", start_q.size(), 32'd0);
        wait_drain("t2");
        tick(); tick();

        // Four simultaneous hits.
        drive_hit(4'b1111, 32'hA0);
        check_val("t3_valid_t1", {31'd0, gn_valid}, 32'd0);
        tick();
        check_val("t3_valid_t2", {31'd0, gn_valid}, 32'd1);
        for (int i = 0; i < NC; i++)
            gn_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < NC; i++)
            pop_one();
        check_val("t3_empty", {31'd0, gn_valid}, 32'd0);
        check_val("t3_ovf", {31'd0, gn_overflow}, 32'd0);
        check_val("t3_hcnt", {16'd0, hit_count}, HC_EN ? 32'd4 : 32'd0);

        // Fill FIFO, park two in holds, then drop one.
        drive_hit(4'b1111, 32'hB0);
        repeat (6) tick();
        drive_hit(4'b0011, 32'hC0);
        repeat (3) tick();
        check_val("t4_no_ovf", {31'd0, gn_overflow}, 32'd0);
        drive_hit(4'b0001, 32'hD0);
        check_val("t4_ovf", {31'd0, gn_overflow}, 32'd1);
        check_val("t4_hcnt", {16'd0, hit_count}, HC_EN ? 32'd10 : 32'd0);
        for (int i = 0; i < NC; i++)
            gn_q.push_back(32'hB0 + 32'(i));
        gn_q.push_back(32'hC0);
        gn_q.push_back(32'hC1);

        // work_load during DRAIN; FIFO contents survive.
        start_q.push_back({4'b1000, 32'hFFFF_FFFF});
        load(32'hFFFF_FFFF);
        check_val("t5_exh_hi", {31'd0, exhausted}, 32'd1);
        start_q.push_back({4'b0001, 32'h200});
        load(32'h200);
        check_val("t5_exh_clr", {31'd0, exhausted}, 32'd0);
        check_val("t5_ovf_clr", {31'd0, gn_overflow}, 32'd0);
        check_val("t5_hcnt_clr", {16'd0, hit_count}, 32'd0);
        start_q.push_back({4'b0010, 32'hFFFF_FFFF});
        load(32'hFFFF_FFFF);
        check_val("t5_exh_again", {31'd0, exhausted}, 32'd1);
        check_val("t5_q_empty", start_q.size(), 32'd0);
        wait_drain("t5");
        for (int i = 0; i < 6; i++)
            pop_one();
        check_val("t5_empty", {31'd0, gn_valid}, 32'd0);
        check_val("t5_ovf", {31'd0, gn_overflow}, 32'd0);

        // Reset mid-DISPATCH with FIFO nonempty, overriding a work_load.
        drive_hit(4'b0100, 32'hE0);
        tick();
        check_val("t6_valid", {31'd0, gn_valid}, 32'd1);
        start_q.push_back({4'b0100, 32'h300});
        load(32'h300);
        check_val("t6_running", {31'd0, running}, 32'd1);
        reset = 1'b1;
        work_load = 1'b1;
        nonce_start = 32'h400;
        tick();
        reset = 1'b0;
        work_load = 1'b0;
        check_reset_vals("t6rst");
        tick(); tick();
        check_val("t6_idle", {31'd0, running}, 32'd0);
        drive_hit(4'b0010, 32'hF0);
        gn_q.push_back(32'hF1);
        pop_one();
        check_val("t6_empty", {31'd0, gn_valid}, 32'd0);
        check_val("t6_hcnt", {16'd0, hit_count}, HC_EN ? 32'd1 : 32'd0);

        check_val("end_start_q", start_q.size(), 32'd0);
        check_val("end_gn_q", gn_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/blake_core_scheduler.md
# blake_core_scheduler

Work scheduler between the host byte interface and the Blake hash cores on each Ztex 1.15y FPGA. Hands out consecutive nonces to NCORES cores round-robin, detects nonce-space exhaustion and drains in-flight work. Arbitrates simultaneous golden-nonce hits into a small FIFO that the host readback path pops.

## Interface
Parameters:
- NCORES, 4, number of hash cores (1..8)
- FIFO_DEPTH, 4, golden-nonce FIFO entries (power of two, >=2)

Ports:
- clk  in  1  core clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- work_load  in  1  one-cycle pulse: new work loaded, restart at nonce_start
- nonce_start  in  32  first nonce of new work, sampled on work_load
- core_start  out  NCORES  one-hot, one-cycle pulse: core i begins hashing core_nonce
- core_nonce  out  32  nonce for the core pulsed in core_start; valid only with core_start
- core_busy  in  NCORES  core i hashing; high from the cycle after its core_start until done
- core_hit  in  NCORES  one-cycle pulse: core i found a golden nonce
- core_hit_nonce  in  32*NCORES  core i's nonce at bits [32i+31:32i], valid with core_hit[i]
- gn_valid  out  1  FIFO head valid
- gn_nonce  out  32  FIFO head
- gn_ack  in  1  pop head; ignored when gn_valid low
- gn_overflow  out  1  sticky: a hit was dropped
- running  out  1  state is DISPATCH or DRAIN
- exhausted  out  1  sticky: nonce 0xFFFFFFFF issued
- hit_count  out  16  hits accepted since work_load (see Configuration)

## Operation
- FSM states IDLE, DISPATCH, DRAIN. IDLE: no starts.
- work_load in any state: next_nonce <= nonce_start, exhausted <= 0, gn_overflow <= 0, state <= DISPATCH. FIFO and hold registers not flushed; host discards stale nonces.
- DISPATCH: each cycle, search from rr pointer for the first core with core_busy=0 and not started in the previous cycle (a 1-cycle start mask covers busy latency). If found: pulse its core_start, drive core_nonce=next_nonce, next_nonce += 1 (mod 2^32), rr <= winner+1 (mod NCORES). At most one start per cycle.
- Issuing nonce 0xFFFFFFFF: exhausted <= 1, state <= DRAIN; no further starts.
- DRAIN: stay until core_busy==0 and start mask clear, then IDLE.
- Hit capture: per-core hold register + valid flag. core_hit[i] with hold i empty (or being emptied this cycle) captures nonce. Hold i still full: new hit dropped, gn_overflow <= 1.
- Hit arbiter: each cycle, one nonempty hold register, round-robin (own pointer), moves into FIFO if FIFO not full or gn_ack pops this cycle. FIFO full with no pop: holds wait, nothing lost.
- Hits accepted in every state including IDLE.

## Timing
- Reset values: core_start=0, core_nonce=0, gn_valid=0, gn_nonce=0, gn_overflow=0, running=0, exhausted=0, hit_count=0; state IDLE; next_nonce=0; rr pointers=0; FIFO, holds empty.
- All outputs registered. work_load in cycle T -> first core_start in T+1 with core_nonce=nonce_start.
- Steady state: one start per cycle while idle cores exist; a core started in T is never restarted before T+2.
- core_hit in T -> hold valid T+1 -> FIFO write end of T+1 -> gn_valid in T+2 (FIFO empty, no contention). 
- gn_ack in T with gn_valid: next head (or gn_valid=0) in T+1. Push and pop same cycle legal when full.
- reset mid-operation overrides work_load and everything else; in-flight core results after reset are still captured.

## Configuration
- SCHED_HIT_COUNT_EN defined: hit_count increments (saturating at 0xFFFF) for each hit accepted into a hold register; cleared by reset and work_load; simultaneous hits add popcount of accepted hits.
- Undefined: no counter logic; hit_count driven constant 0.

## Test plan
- Reset, NCORES=4, cores busy 10 cycles: work_load nonce_start=0x100 -> core_start 0001,0010,0100,1000 in T+1..T+4 with nonces 0x100..0x103; next start only after a core drops busy, nonce 0x104.
- nonce_start=0xFFFFFFFE -> two starts (0xFFFFFFFE, 0xFFFFFFFF), exhausted=1, state DRAIN, running falls one cycle after all core_busy low, no third start.
- core_hit=1111 same cycle, nonces 0xA0..0xA3 -> gn_valid from T+2, pops yield all four in round-robin order, gn_overflow=0; with SCHED_HIT_COUNT_EN hit_count=4.
- FIFO_DEPTH=4, no gn_ack, 6 hits spread over cores -> 4 in FIFO, 2 held, no overflow; then second hit on a held core -> gn_overflow=1, that nonce never appears.
- work_load during DRAIN -> exhausted and gn_overflow clear, core_start resumes next cycle from new nonce_start; FIFO content preserved.
- reset asserted mid-DISPATCH with FIFO nonempty -> next cycle all outputs at reset values, gn_valid=0.
